video_in_store: RTL and testbench
=================================

Name: video_in_store

Overview:
Capture-side stage that produces the frame buffers read back by the video output path. It accepts an 8-bit pixel stream qualified by frame_valid/line_valid, packs 4 pixels per 32-bit word and buffers the words in a small word FIFO. It writes each word to RAM through a Wishbone master at the frame base address taken from the register slave. It pulses interrupt once a complete frame is in RAM.

Parameters:
HRES, 640, active pixels per line; must be a multiple of 4.
VRES, 480, active lines per frame.
FIFO_ADDR_SIZE, 4, log2 of the internal word FIFO depth (default depth 16 words).

Ports:
clk  in  1  system clock, 100 MHz
nRST  in  1  asynchronous reset, active low
wb_reg_data  in  32  frame base address in bytes; bits [1:0] are ignored
wb_reg_ctr  in  32  control word; bit0 = capture enable
pixel_en  in  1  pixel qualifier strobe; one pixel per strobe
frame_valid  in  1  frame active
line_valid  in  1  line active
pixel_in  in  8  pixel data
interrupt  out  1  one-cycle pulse when a frame has been fully written
overflow  out  1  sticky flag: a word or frame was dropped
p_wb_STB_O  out  1  Wishbone strobe
p_wb_CYC_O  out  1  Wishbone cycle
p_wb_LOCK_O  out  1  tied to 0
p_wb_SEL_O  out  4  byte select; 4'hF during a cycle, otherwise 0
p_wb_WE_O  out  1  write enable; 1 during a cycle
p_wb_ADR_O  out  32  byte address
p_wb_DAT_O  out  32  write data
p_wb_ACK_I  in  1  Wishbone acknowledge

Behaviour:
- Reset (nRST low, asynchronous): every output is 0. FIFO is empty, packer is cleared, word index is 0, FSM is in IDLE, capture is off, overflow is 0.
- Frame start: detected on a registered rising edge of frame_valid.
  - If wb_reg_ctr[0]=1 and the previous frame is not still draining: latch base = {wb_reg_data[31:2],2'b00}, clear word_idx and the packer, set capturing=1.
  - If the enable bit is 0: the frame is ignored.
  - If the previous frame is still draining: the new frame is ignored and overflow is set.
- The enable bit is sampled only at frame start. Clearing it mid-frame does not stop the current frame.
- Pixel accept: a pixel is taken on a cycle where capturing && pixel_en && frame_valid && line_valid.
- Packing is little-endian: the first pixel goes to [7:0], the fourth to [31:24]. On the 4th pixel the word is pushed into the FIFO in the same cycle.
- FIFO full at push: the word is dropped, overflow is set, and the packer restarts.
- Word-count limit: after HRES*VRES/4 words have been pushed in a frame, further pixels are discarded with no overflow.
- Write FSM, IDLE state: when the FIFO is not empty, drive the bus on the next edge and go to BUS.
  - CYC=STB=WE=1, SEL=F.
  - ADR = base + 4*word_idx, modulo 2^32.
  - DAT = FIFO head.
- Write FSM, BUS state: hold all bus outputs stable until ACK_I. On the ACK cycle:
  - pop the FIFO and increment word_idx;
  - on the next edge drop CYC/STB/WE/SEL and return to IDLE.
  - This gives at least one idle cycle between transfers. ACK_I seen outside BUS is ignored.
- Push and pop may occur in the same cycle; the FIFO count is then unchanged.
- Frame end: a registered falling edge of frame_valid while capturing sets end_pending and clears capturing.
  - A partial packer word is discarded.
  - When end_pending && FIFO empty && FSM in IDLE, interrupt is high for exactly 1 cycle and end_pending is cleared.
  - "Draining" means end_pending=1.
- A short frame (fewer than HRES*VRES/4 words) still raises interrupt once its words are written.
- overflow is cleared only by reset.
- Reset mid-transfer: the bus is released asynchronously and the frame is lost.

Test Plan:
- HRES=8, VRES=2, base 0x1000, enable=1, pixels 0x00..0x0F, ACK one cycle after STB -> 4 writes:
  - ADR 0x1000, 0x1004, 0x1008, 0x100C;
  - DAT 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C;
  - one interrupt pulse after the last ACK; overflow=0.
- Same frame with enable=0 -> no CYC ever, no interrupt.
- ACK delayed 40 cycles, pixel_en every cycle, depth 16, HRES=128 -> overflow=1. Addresses of written words stay contiguous from base, and interrupt is still raised.
- Frame with 18 accepted pixels, HRES=8 -> 4 words written, the 2 extra pixels discarded, one interrupt.
- wb_reg_data changed and enable cleared mid-frame -> current frame completes at the old base. The next frame is not captured.
- nRST asserted during a BUS cycle -> STB/CYC/WE, interrupt and overflow go to 0 immediately. After release, the next enabled frame writes from its new base with word_idx 0.

Source files
------------

// File: rtl/video_in_store.sv
// video_in_store: capture-side frame writer.
// Packs an 8-bit pixel stream into 32-bit little-endian words, buffers them in
// a small word FIFO and writes them to RAM through a single-beat Wishbone
// master at consecutive addresses starting at the frame base. A one-cycle
// interrupt marks a frame that is completely in RAM.
module video_in_store #(
  parameter int HRES           = 640,
  parameter int VRES           = 480,
  parameter int FIFO_ADDR_SIZE = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  input  logic        pixel_en,
  input  logic        frame_valid,
  input  logic        line_valid,
  input  logic [7:0]  pixel_in,
  output logic        interrupt,
  output logic        overflow,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic        p_wb_ACK_I
);

  localparam int          DEPTH = 1 << FIFO_ADDR_SIZE;
  localparam logic [31:0] WORDS = 32'(HRES * VRES / 4);

  typedef enum logic {IDLE, BUS} state_t;

  state_t state;

  // frame tracking
  logic        fv_q;
  logic        capturing;
  logic        end_pending;
  logic [31:0] base;
  logic [29:0] word_idx;

  // packer
  logic [23:0] pack;
  logic [1:0]  pcnt;
  logic [31:0] words_pushed;

  // word FIFO
  logic [31:0]               mem [DEPTH];
  logic [FIFO_ADDR_SIZE-1:0] wptr, rptr;
  logic [FIFO_ADDR_SIZE:0]   count;

  logic frame_start, frame_stop, start_ok;
  logic limit, accept, push_req, push, pop, full, empty;
  logic [31:0] word_in;

  // the low address bits and the upper control bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

  assign frame_start = frame_valid & ~fv_q;
  assign frame_stop  = ~frame_valid & fv_q;
  // a new frame is taken only when the previous one has fully drained
  assign start_ok    = frame_start & wb_reg_ctr[0] & ~end_pending;

  assign full     = count[FIFO_ADDR_SIZE];
  assign empty    = (count == '0);
  assign limit    = (words_pushed == WORDS);
  assign accept   = capturing & pixel_en & frame_valid & line_valid & ~limit;
  assign push_req = accept & (pcnt == 2'd3);
  assign push     = push_req & ~full;
  assign pop      = (state == BUS) & p_wb_ACK_I;
  assign word_in  = {pixel_in, pack};

  assign p_wb_LOCK_O = 1'b0;

  // frame start/end, base latch, write index, overflow and interrupt
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      fv_q        <= 1'b0;
      capturing   <= 1'b0;
      end_pending <= 1'b0;
      base        <= '0;
      word_idx    <= '0;
      overflow    <= 1'b0;
      interrupt   <= 1'b0;
    end else begin
      fv_q      <= frame_valid;
      interrupt <= 1'b0;
      if (frame_start && wb_reg_ctr[0]) begin
        if (end_pending) begin
          overflow <= 1'b1;
        end else begin
          base      <= {wb_reg_data[31:2], 2'b00};
          capturing <= 1'b1;
        end
      end
      if (frame_stop && capturing) begin
        capturing   <= 1'b0;
        end_pending <= 1'b1;
      end
      // all words written and no transfer in flight: frame is in RAM
      if (end_pending && empty && state == IDLE) begin
        interrupt   <= 1'b1;
        end_pending <= 1'b0;
      end
      if (push_req && full) overflow <= 1'b1;
      if (start_ok)  word_idx <= '0;
      else if (pop)  word_idx <= word_idx + 30'd1;
    end
  end

  // little-endian 4-pixel packer with per-frame word limit
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pack         <= '0;
      pcnt         <= '0;
      words_pushed <= '0;
    end else if (start_ok) begin
      pcnt         <= '0;
      words_pushed <= '0;
    end else if (frame_stop) begin
      // a partially filled word at frame end is discarded
      pcnt <= '0;
    end else if (accept) begin
      pcnt <= pcnt + 2'd1;
      case (pcnt)
        2'd0:    pack[7:0]   <= pixel_in;
        2'd1:    pack[15:8]  <= pixel_in;
        2'd2:    pack[23:16] <= pixel_in;
        default: if (push) words_pushed <= words_pushed + 32'd1;
      endcase
    end
  end

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= word_in;
  end

  // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // single-beat Wishbone write FSM with registered bus outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      p_wb_STB_O <= 1'b0;
      p_wb_CYC_O <= 1'b0;
      p_wb_WE_O  <= 1'b0;
      p_wb_SEL_O <= 4'h0;
      p_wb_ADR_O <= '0;
      p_wb_DAT_O <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= BUS;
            p_wb_STB_O <= 1'b1;
            p_wb_CYC_O <= 1'b1;
            p_wb_WE_O  <= 1'b1;
            p_wb_SEL_O <= 4'hF;
            p_wb_ADR_O <= base + {word_idx, 2'b00};
            p_wb_DAT_O <= mem[rptr];
          end
        end
        BUS: begin
          // release after the ack; the IDLE visit guarantees a gap cycle
          if (p_wb_ACK_I) begin
            state      <= IDLE;
            p_wb_STB_O <= 1'b0;
            p_wb_CYC_O <= 1'b0;
            p_wb_WE_O  <= 1'b0;
            p_wb_SEL_O <= 4'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_in_store.sv
// Directed bench for video_in_store: two instances (small frame and wide-line
// frame) sharing the pixel stream, each with its own Wishbone slave model.
module tb_video_in_store;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] data;
  logic [31:0] ctr1, ctr2;
  logic        pixel_en, frame_valid, line_valid;
  logic [7:0]  pixel_in;

  logic        irq1, ovf1, stb1, cyc1, lock1, we1, ack1;
  logic [3:0]  sel1;
  logic [31:0] adr1, dat1;
  logic        irq2, ovf2, stb2, cyc2, lock2, we2, ack2;
  logic [3:0]  sel2;
  logic [31:0] adr2, dat2;

  int tests = 0;
  int fails = 0;

  // slave models and logs
  int          dly1 = 0, dly2 = 0, cnt1 = 0, cnt2 = 0;
  int          n1 = 0, n2 = 0, irq_n1 = 0, irq_n2 = 0, cyc_n1 = 0;
  logic [31:0] log_adr1 [64];
  logic [31:0] log_dat1 [64];
  logic [4:0]  log_aux1 [64];
  logic [31:0] log_adr2 [64];
  logic [31:0] log_dat2 [64];

  always #5 clk = ~clk;

  video_in_store #(.HRES(8), .VRES(2), .FIFO_ADDR_SIZE(4)) dut1 (
    .clk(clk), .nRST(nRST), .wb_reg_data(data), .wb_reg_ctr(ctr1),
    .pixel_en(pixel_en), .frame_valid(frame_valid), .line_valid(line_valid),
    .pixel_in(pixel_in), .interrupt(irq1), .overflow(ovf1),
    .p_wb_STB_O(stb1), .p_wb_CYC_O(cyc1), .p_wb_LOCK_O(lock1),
    .p_wb_SEL_O(sel1), .p_wb_WE_O(we1), .p_wb_ADR_O(adr1),
    .p_wb_DAT_O(dat1), .p_wb_ACK_I(ack1)
  );

  video_in_store #(.HRES(128), .VRES(1), .FIFO_ADDR_SIZE(4)) dut2 (
    .clk(clk), .nRST(nRST), .wb_reg_data(data), .wb_reg_ctr(ctr2),
    .pixel_en(pixel_en), .frame_valid(frame_valid), .line_valid(line_valid),
    .pixel_in(pixel_in), .interrupt(irq2), .overflow(ovf2),
    .p_wb_STB_O(stb2), .p_wb_CYC_O(cyc2), .p_wb_LOCK_O(lock2),
    .p_wb_SEL_O(sel2), .p_wb_WE_O(we2), .p_wb_ADR_O(adr2),
    .p_wb_DAT_O(dat2), .p_wb_ACK_I(ack2)
  );

  // slave 1: ack dly1+1 negedges after STB is seen, log each acked beat
  always @(negedge clk) begin
    if (ack1) ack1 <= 1'b0;
    else if (cyc1 && stb1) begin
      if (cnt1 >= dly1) begin
        ack1 <= 1'b1;
        cnt1 <= 0;
        if (n1 < 64) begin
          log_adr1[n1] <= adr1;
          log_dat1[n1] <= dat1;
          log_aux1[n1] <= {we1, sel1};
        end
        n1 <= n1 + 1;
      end else cnt1 <= cnt1 + 1;
    end else cnt1 <= 0;
    if (irq1) irq_n1 <= irq_n1 + 1;
    if (cyc1) cyc_n1 <= cyc_n1 + 1;
  end

  // slave 2
  always @(negedge clk) begin
    if (ack2) ack2 <= 1'b0;
    else if (cyc2 && stb2) begin
      if (cnt2 >= dly2) begin
        ack2 <= 1'b1;
        cnt2 <= 0;
        if (n2 < 64) begin
          log_adr2[n2] <= adr2;
          log_dat2[n2] <= dat2;
        end
        n2 <= n2 + 1;
      end else cnt2 <= cnt2 + 1;
    end else cnt2 <= 0;
    if (irq2) irq_n2 <= irq_n2 + 1;
  end

  initial begin
    ack1 = 1'b0;
    ack2 = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one frame: lines of per_line pixels, junk strobes in the line gaps;
  // at pixel chg_at the base register changes and capture enable drops
  task automatic send_frame(input int npix, input int per_line, input logic [7:0] v0,
                            input int chg_at, input logic [31:0] newdata);
    @(negedge clk);
    frame_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < npix; i++) begin
      if (i != 0 && (i % per_line) == 0) begin
        line_valid = 1'b0;
        pixel_en   = 1'b1;
        pixel_in   = 8'hEE;
        @(negedge clk);
        @(negedge clk);
      end
      if (i == chg_at) begin
        data = newdata;
        ctr1 = 32'd0;
      end
      line_valid = 1'b1;
      pixel_en   = 1'b1;
      pixel_in   = v0 + 8'(i);
      @(negedge clk);
    end
    line_valid = 1'b0;
    pixel_en   = 1'b0;
    @(negedge clk);
    frame_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_irq(input int which, input int snap, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if ((which == 1 ? irq_n1 : irq_n2) != snap) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int s_n, s_irq, s_cyc;
    logic [31:0] b;
    nRST = 1'b1;
    data = 32'd0; ctr1 = 32'd0; ctr2 = 32'd0;
    pixel_en = 1'b0; frame_valid = 1'b0; line_valid = 1'b0; pixel_in = 8'd0;
    #2 nRST = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_stb", {31'd0, stb1}, 32'd0);
    chk("rst_cyc", {31'd0, cyc1}, 32'd0);
    chk("rst_we", {31'd0, we1}, 32'd0);
    chk("rst_sel", {28'd0, sel1}, 32'd0);
    chk("rst_adr", adr1, 32'd0);
    chk("rst_dat", dat1, 32'd0);
    chk("rst_irq", {31'd0, irq1}, 32'd0);
    chk("rst_ovf", {31'd0, ovf1}, 32'd0);
    chk("rst_lock", {31'd0, lock1}, 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // basic 8x2 frame at 0x1000, ack one cycle after STB
    data = 32'h0000_1000; ctr1 = 32'd1; dly1 = 0;
    s_n = n1; s_irq = irq_n1;
    send_frame(16, 8, 8'h00, -1, 32'd0);
    wait_irq(1, s_irq, 200);
    chk("t1_nwords", n1 - s_n, 32'd4);
    chk("t1_adr0", log_adr1[s_n],     32'h0000_1000);
    chk("t1_adr1", log_adr1[s_n + 1], 32'h0000_1004);
    chk("t1_adr2", log_adr1[s_n + 2], 32'h0000_1008);
    chk("t1_adr3", log_adr1[s_n + 3], 32'h0000_100C);
    chk("t1_dat0", log_dat1[s_n],     32'h0302_0100);
    chk("t1_dat1", log_dat1[s_n + 1], 32'h0706_0504);
    chk("t1_dat2", log_dat1[s_n + 2], 32'h0B0A_0908);
    chk("t1_dat3", log_dat1[s_n + 3], 32'h0F0E_0D0C);
    chk("t1_we_sel", {27'd0, log_aux1[s_n]}, 32'h0000_001F);
    chk("t1_irq", irq_n1 - s_irq, 32'd1);
    chk("t1_ovf", {31'd0, ovf1}, 32'd0);
    chk("t1_idle_cyc", {31'd0, cyc1}, 32'd0);

    // capture disabled: no bus activity, no interrupt
    ctr1 = 32'd0;
    s_cyc = cyc_n1; s_irq = irq_n1;
    send_frame(16, 8, 8'h20, -1, 32'd0);
    repeat (50) @(negedge clk);
    chk("t2_cyc", cyc_n1 - s_cyc, 32'd0);
    chk("t2_irq", irq_n1 - s_irq, 32'd0);

    // 18 pixels into a 4-word frame; base low bits ignored
    data = 32'h0000_1003; ctr1 = 32'd1;
    s_n = n1; s_irq = irq_n1;
    send_frame(18, 8, 8'h40, -1, 32'd0);
    wait_irq(1, s_irq, 200);
    chk("t4_nwords", n1 - s_n, 32'd4);
    chk("t4_adr0", log_adr1[s_n],     32'h0000_1000);
    chk("t4_adr3", log_adr1[s_n + 3], 32'h0000_100C);
    chk("t4_dat3", log_dat1[s_n + 3], 32'h4F4E_4D4C);
    chk("t4_irq", irq_n1 - s_irq, 32'd1);
    chk("t4_ovf", {31'd0, ovf1}, 32'd0);

    // base and enable change mid-frame: frame finishes at old base
    data = 32'h0000_2000; ctr1 = 32'd1;
    s_n = n1; s_irq = irq_n1;
    send_frame(16, 8, 8'h60, 6, 32'h0000_5000);
    wait_irq(1, s_irq, 200);
    chk("t5_nwords", n1 - s_n, 32'd4);
    chk("t5_adr0", log_adr1[s_n],     32'h0000_2000);
    chk("t5_adr3", log_adr1[s_n + 3], 32'h0000_200C);
    chk("t5_dat3", log_dat1[s_n + 3], 32'h6F6E_6D6C);
    chk("t5_irq", irq_n1 - s_irq, 32'd1);
    s_cyc = cyc_n1; s_irq = irq_n1;
    send_frame(16, 8, 8'h70, -1, 32'd0);
    repeat (50) @(negedge clk);
    chk("t5_next_cyc", cyc_n1 - s_cyc, 32'd0);
    chk("t5_next_irq", irq_n1 - s_irq, 32'd0);

    // slow slave on a 128-pixel line: FIFO overflows, addresses wrap mod 2^32
    b = 32'hFFFF_FFC0;
    data = b; ctr2 = 32'd1; dly2 = 40;
    s_irq = irq_n2;
    send_frame(128, 128, 8'h00, -1, 32'd0);
    wait_irq(2, s_irq, 3000);
    ctr2 = 32'd0;
    chk("t3_ovf", {31'd0, ovf2}, 32'd1);
    chk("t3_irq", irq_n2 - s_irq, 32'd1);
    chk("t3_nwords_range", {31'd0, (n2 >= 16 && n2 < 32)}, 32'd1);
    chk("t3_dat0", log_dat2[0], 32'h0302_0100);
    for (int k = 0; k < n2 && k < 64; k++)
      chk($sformatf("t3_adr%0d", k), log_adr2[k], b + 32'(4 * k));

    // reset during a bus cycle
    data = 32'h0000_3000; ctr1 = 32'd1; dly1 = 20;
    send_frame(16, 8, 8'h90, -1, 32'd0);
    for (int i = 0; i < 100 && !cyc1; i++) @(negedge clk);
    chk("t6_in_bus", {31'd0, cyc1}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("t6_cyc", {31'd0, cyc1}, 32'd0);
    chk("t6_stb", {31'd0, stb1}, 32'd0);
    chk("t6_we", {31'd0, we1}, 32'd0);
    chk("t6_irq", {31'd0, irq1}, 32'd0);
    chk("t6_ovf2", {31'd0, ovf2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
    dly1 = 0;
    @(negedge clk);
    data = 32'h0000_6000;
    s_n = n1; s_irq = irq_n1;
    send_frame(16, 8, 8'h80, -1, 32'd0);
    wait_irq(1, s_irq, 200);
    chk("t6_nwords", n1 - s_n, 32'd4);
    chk("t6_adr0", log_adr1[s_n],     32'h0000_6000);
    chk("t6_dat0", log_dat1[s_n],     32'h8382_8180);
    chk("t6_adr3", log_adr1[s_n + 3], 32'h0000_600C);
    chk("t6_irq_after", irq_n1 - s_irq, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard stop in case anything above stalls
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
